id_hazard_ctrl: RTL and testbench



---
 rtl/id_hazard_ctrl_pkg.sv | 28 ++
 rtl/id_hazard_ctrl_sat_counter.sv | 23 ++
 rtl/id_hazard_ctrl.sv | 120 ++++++++++++
 tb/tb_id_hazard_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/id_hazard_ctrl_pkg.sv
// Shared types and constants for the ID-stage hazard/sequencing controller.
package id_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    TIMEOUT  = 2'd3
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // ID/EX control-field widths and position of memread inside the M field
  localparam int WB_W          = 2;
  localparam int M_W           = 3;
  localparam int EX_W          = 4;
  localparam int M_MEMREAD_BIT = 1;

  function automatic logic load_use(input logic       ex_memread,
                                    input logic [4:0] ex_rt,
                                    input logic [4:0] id_rs,
                                    input logic [4:0] id_rt,
                                    input logic       id_uses_rt);
    return ex_memread && (ex_rt != REG_ZERO) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/id_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
module sat_counter #(
  parameter int           W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Load-use / branch-flush / memory-stall sequencing for the ID stage.
// Optional statistics outputs are enabled by defining HAZARD_STATS_EN.
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 8,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  input  logic             dmem_wait,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_flush,
  output logic             pipe_freeze,
`ifdef HAZARD_STATS_EN
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] lu_count,
`endif
  output logic             timeout_err
);

  state_t            state_reg, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              cnt_inc, cnt_clr, lu_stall;
  logic              lu;
  logic              pc_w_c, if_w_c, if_f_c, bub_c, exf_c, frz_c;

  assign lu = load_use(ex_memread, ex_rt, id_rs, id_rt, id_uses_rt);

  always_comb begin
    pc_w_c     = 1'b1;
    if_w_c     = 1'b1;
    if_f_c     = 1'b0;
    bub_c      = 1'b0;
    exf_c      = 1'b0;
    frz_c      = 1'b0;
    cnt_inc    = 1'b0;
    cnt_clr    = 1'b0;
    lu_stall   = 1'b0;
    state_next = state_reg;
    case (state_reg)
      RUN, LU_STALL, MEM_WAIT: begin
        // Memory stall outranks a branch: the branch stays parked in MEM
        if (dmem_wait) begin
          pc_w_c  = 1'b0;
          if_w_c  = 1'b0;
          frz_c   = 1'b1;
          cnt_inc = 1'b1;
          if (state_reg == MEM_WAIT && wait_cnt == WAIT_W'(MAX_WAIT))
            state_next = TIMEOUT;
          else
            state_next = MEM_WAIT;
        end else begin
          cnt_clr = 1'b1;
          if (branch_taken) begin
            if_f_c     = 1'b1;
            bub_c      = 1'b1;
            exf_c      = 1'b1;
            state_next = RUN;
          end else if (lu && state_reg != LU_STALL) begin
            pc_w_c     = 1'b0;
            if_w_c     = 1'b0;
            bub_c      = 1'b1;
            lu_stall   = 1'b1;
            state_next = LU_STALL;
          end else begin
            state_next = RUN;
          end
        end
      end
      default: begin
        pc_w_c = 1'b0;
        if_w_c = 1'b0;
        frz_c  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= RUN;
    else        state_reg <= state_next;
  end

  sat_counter #(.W(WAIT_W), .MAX(WAIT_W'(MAX_WAIT))) u_wait_cnt (
    .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .en(cnt_inc), .cnt(wait_cnt)
  );

  // Reset forces a squash-everything, hold-fetch pattern into the pipeline
  assign pc_write     = rst_n & pc_w_c;
  assign if_id_write  = rst_n & if_w_c;
  assign if_id_flush  = ~rst_n | if_f_c;
  assign id_ex_bubble = ~rst_n | bub_c;
  assign ex_mem_flush = ~rst_n | exf_c;
  assign pipe_freeze  = rst_n & frz_c;
  assign timeout_err  = rst_n & (state_reg == TIMEOUT);

`ifdef HAZARD_STATS_EN
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .en(~pc_write), .cnt(stall_cycles)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .en(if_id_flush), .cnt(flush_count)
  );
  sat_counter #(.W(CNT_W)) u_lu_cnt (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .en(lu_stall), .cnt(lu_count)
  );
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Scoreboard bench for id_hazard_ctrl: directed test-plan sequences, then random traffic.
module tb_id_hazard_ctrl;

  localparam int MAXW = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic       id_uses_rt = 1'b0, ex_memread = 1'b0, branch_taken = 1'b0, dmem_wait = 1'b0;
  logic       pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, pipe_freeze, timeout_err;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles, flush_count, lu_count;
`endif

  always #5 clk = ~clk;

  id_hazard_ctrl #(.MAX_WAIT(MAXW), .WAIT_W(8), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt),
    .branch_taken(branch_taken), .dmem_wait(dmem_wait),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_mem_flush(ex_mem_flush), .pipe_freeze(pipe_freeze),
`ifdef HAZARD_STATS_EN
    .stall_cycles(stall_cycles), .flush_count(flush_count), .lu_count(lu_count),
`endif
    .timeout_err(timeout_err)
  );

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, pipe_freeze, timeout_err}
  typedef logic [6:0] exp_t;
  exp_t exp_q[$];
  int   compared = 0, mismatched = 0, txn = 0;

  // Reference model: counts consecutive memory-wait cycles, remembers whether the
  // last cycle was a load-use bubble, and whether the core has locked up.
  int   m_waits = 0;
  bit   m_after_lu = 1'b0, m_dead = 1'b0;

  task automatic step(input bit r, input logic [4:0] rs, input logic [4:0] rt, input bit ur,
                      input bit mr, input logic [4:0] ert, input bit br, input bit dw);
    exp_t e;
    bit   lu;
    @(posedge clk);
    #1;
    rst_n = r; id_rs = rs; id_rt = rt; id_uses_rt = ur;
    ex_memread = mr; ex_rt = ert; branch_taken = br; dmem_wait = dw;
    lu = mr && (ert != 0) && ((ert == rs) || (ur && (ert == rt)));
    if (!r) begin
      e = 7'b0011100;
      m_waits = 0; m_after_lu = 1'b0; m_dead = 1'b0;
    end else if (m_dead) begin
      e = 7'b0000011;
    end else if (dw) begin
      e = 7'b0000010;
      if (m_waits == MAXW) m_dead = 1'b1;
      m_waits++;
      m_after_lu = 1'b0;
    end else begin
      m_waits = 0;
      if (br) begin
        e = 7'b1111100; m_after_lu = 1'b0;
      end else if (lu && !m_after_lu) begin
        e = 7'b0001000; m_after_lu = 1'b1;
      end else begin
        e = 7'b1100000; m_after_lu = 1'b0;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0);
  endtask

  // Monitor: outputs are combinational, so sample mid-cycle on the falling edge
  always @(negedge clk) begin
    exp_t e, got;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, pipe_freeze, timeout_err};
      compared++;
      txn++;
      if (got !== e) begin
        mismatched++;
        $display("FAIL ctrl_outputs txn=%0d t=%0t got=%b expected=%b", txn, $time, got, e);
      end else begin
        $display("txn=%0d t=%0t outputs=%b ok", txn, $time, got);
      end
    end
  end

  initial begin
    int drain;
    // reset, then release with idle inputs
    step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0);
    idle(2);
    // load-use on rs, then one bubble only
    step(1, 5'd8, 5'd0, 0, 1, 5'd8, 0, 0);
    step(1, 5'd8, 5'd0, 0, 0, 5'd8, 0, 0);
    // load-use still visible during the bubble cycle: no second stall
    step(1, 5'd8, 5'd0, 0, 1, 5'd8, 0, 0);
    step(1, 5'd8, 5'd0, 0, 1, 5'd8, 0, 0);
    // $zero and unused rt never stall
    step(1, 5'd0, 5'd0, 0, 1, 5'd0, 0, 0);
    step(1, 5'd3, 5'd9, 0, 1, 5'd9, 0, 0);
    // rt used as a source stalls
    step(1, 5'd3, 5'd9, 1, 1, 5'd9, 0, 0);
    idle(1);
    // branch coincident with load-use: flush wins
    step(1, 5'd8, 5'd0, 0, 1, 5'd8, 1, 0);
    idle(1);
    // 3-cycle memory stall, then resume
    repeat (3) step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1);
    idle(2);
    // branch during memory stall is deferred, then taken on release
    step(1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1);
    step(1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0);
    // load-use pending at memory release acts immediately
    step(1, 5'd4, 5'd0, 0, 1, 5'd4, 0, 1);
    step(1, 5'd4, 5'd0, 0, 1, 5'd4, 0, 0);
    idle(1);
    // exactly MAX_WAIT stall cycles is tolerated
    repeat (MAXW) step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1);
    idle(1);
    // held wait -> timeout, sticky after dmem_wait drops, cleared by reset pulse
    repeat (MAXW + 3) step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1);
    idle(3);
    step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0);
    idle(2);

    // random traffic over a small register range so hazards are frequent
    for (int i = 0; i < 1500; i++) begin
      bit r;
      r = ($urandom_range(0, 99) != 0);
      step(r, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
    end

    drain = 0;
    while (exp_q.size() > 0 && drain < 20) begin
      @(posedge clk);
      drain++;
    end
    if (exp_q.size() > 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
